// File: rtl/dispatch_stage_if.sv
// Shared processor types plus the dispatch-stage handshake bundle
// (rename side in, issue side out, writeback/commit sidebands).
package processor_help;
  localparam int SUPER_SCALAR_WIDTH = 2;
  localparam int PHYSICAL_REGISTER_FILE_SIZE = 64;
  localparam int PHYS_REG_WIDTH = $clog2(PHYSICAL_REGISTER_FILE_SIZE);

  typedef struct packed {
    logic [7:0]                opcode;
    logic [PHYS_REG_WIDTH-1:0] destination_register;
    logic [PHYS_REG_WIDTH-1:0] source_register_1;
    logic [PHYS_REG_WIDTH-1:0] source_register_2;
  } RenameResult;
endpackage

interface dispatch_stage_if #(
  parameter int ROB_DEPTH       = 32,
  parameter int WRITEBACK_PORTS = 2
);
  localparam int W  = processor_help::SUPER_SCALAR_WIDTH;
  localparam int PW = processor_help::PHYS_REG_WIDTH;
  localparam int TW = $clog2(ROB_DEPTH);
  localparam int CW = $clog2(W + 1);

  logic                                 rename_ready_out;
  logic                                 rename_valid_in;
  processor_help::RenameResult [W-1:0]  rename_payload_in;
  logic                                 issue_ready_in;
  logic                                 issue_valid_out;
  processor_help::RenameResult [W-1:0]  issue_payload_out;
  logic [W-1:0][TW-1:0]                 issue_rob_tag_out;
  logic [W-1:0]                         issue_src1_ready_out;
  logic [W-1:0]                         issue_src2_ready_out;
  logic [WRITEBACK_PORTS-1:0]           writeback_valid_in;
  logic [WRITEBACK_PORTS-1:0][PW-1:0]   writeback_tag_in;
  logic [CW-1:0]                        commit_count_in;

  modport master (
    output rename_valid_in, rename_payload_in, issue_ready_in,
           writeback_valid_in, writeback_tag_in, commit_count_in,
    input  rename_ready_out, issue_valid_out, issue_payload_out,
           issue_rob_tag_out, issue_src1_ready_out, issue_src2_ready_out
  );

  modport slave (
    input  rename_valid_in, rename_payload_in, issue_ready_in,
           writeback_valid_in, writeback_tag_in, commit_count_in,
    output rename_ready_out, issue_valid_out, issue_payload_out,
           issue_rob_tag_out, issue_src1_ready_out, issue_src2_ready_out
  );
endinterface

// File: rtl/dispatch_stage.sv
// Dispatch: ROB tag/credit allocation, physical-register busy tracking with
// writeback wakeup, and a single registered output stage toward the issue queue.
module dispatch_stage #(
  parameter int ROB_DEPTH       = 32,
  parameter int WRITEBACK_PORTS = 2
) (
  input  logic          clk_in,
  input  logic          rst_in,
  dispatch_stage_if.slave bus
);
  import processor_help::*;

  localparam int W   = SUPER_SCALAR_WIDTH;
  localparam int P   = PHYSICAL_REGISTER_FILE_SIZE;
  localparam int PW  = PHYS_REG_WIDTH;
  localparam int TW  = $clog2(ROB_DEPTH);
  localparam int CRW = $clog2(ROB_DEPTH + 1);

  logic                 valid_q, valid_d;
  RenameResult [W-1:0]  payload_q, payload_d;
  logic [W-1:0][TW-1:0] tag_q, tag_d;
  logic [W-1:0]         src1_ready_q, src1_ready_d;
  logic [W-1:0]         src2_ready_q, src2_ready_d;
  logic [P-1:0]         busy_q, busy_d;
  logic [TW-1:0]        rob_tail_q, rob_tail_d;
  logic [CRW-1:0]       credits_q, credits_d;
  logic [CRW:0]         credits_sum;

  logic [W-1:0] acc_src1, acc_src2, hold_src1, hold_src2;
  logic         rename_ready, accept;

  assign rename_ready = (!valid_q || bus.issue_ready_in) && (credits_q >= CRW'(W));
  assign accept       = bus.rename_valid_in && rename_ready;

  for (genvar gi = 0; gi < W; gi++) begin : g_slot
    logic [PW-1:0] in_s1, in_s2, out_s1, out_s2;
    logic          a1, a2, h1, h2;

    assign in_s1  = bus.rename_payload_in[gi].source_register_1;
    assign in_s2  = bus.rename_payload_in[gi].source_register_2;
    assign out_s1 = payload_q[gi].source_register_1;
    assign out_s2 = payload_q[gi].source_register_2;

    always_comb begin
      a1 = !busy_q[in_s1];
      a2 = !busy_q[in_s2];
      h1 = src1_ready_q[gi] || (out_s1 == '0);
      h2 = src2_ready_q[gi] || (out_s2 == '0);
      for (int k = 0; k < WRITEBACK_PORTS; k++) begin
        if (bus.writeback_valid_in[k]) begin
          if (bus.writeback_tag_in[k] == in_s1)  a1 = 1'b1;
          if (bus.writeback_tag_in[k] == in_s2)  a2 = 1'b1;
          if (bus.writeback_tag_in[k] == out_s1) h1 = 1'b1;
          if (bus.writeback_tag_in[k] == out_s2) h2 = 1'b1;
        end
      end
      // An older slot in the same group producing this source beats any bypass.
      for (int j = 0; j < gi; j++) begin
        if (bus.rename_payload_in[j].destination_register != '0) begin
          if (bus.rename_payload_in[j].destination_register == in_s1) a1 = 1'b0;
          if (bus.rename_payload_in[j].destination_register == in_s2) a2 = 1'b0;
        end
      end
      if (in_s1 == '0) a1 = 1'b1;
      if (in_s2 == '0) a2 = 1'b1;
    end

    assign acc_src1[gi]  = a1;
    assign acc_src2[gi]  = a2;
    assign hold_src1[gi] = h1;
    assign hold_src2[gi] = h2;
  end

  always_comb begin
    credits_sum = {1'b0, credits_q} + (CRW+1)'(bus.commit_count_in)
                - (accept ? (CRW+1)'(W) : '0);
    credits_d   = credits_sum[CRW-1:0];
    rob_tail_d  = accept ? rob_tail_q + TW'(W) : rob_tail_q;

    // Clears first, then sets, so a same-cycle allocation stays busy.
    busy_d = busy_q;
    for (int k = 0; k < WRITEBACK_PORTS; k++) begin
      if (bus.writeback_valid_in[k]) busy_d[bus.writeback_tag_in[k]] = 1'b0;
    end
    if (accept) begin
      for (int i = 0; i < W; i++) begin
        if (bus.rename_payload_in[i].destination_register != '0)
          busy_d[bus.rename_payload_in[i].destination_register] = 1'b1;
      end
    end

    valid_d      = valid_q;
    payload_d    = payload_q;
    tag_d        = tag_q;
    src1_ready_d = src1_ready_q;
    src2_ready_d = src2_ready_q;
    if (accept) begin
      valid_d   = 1'b1;
      payload_d = bus.rename_payload_in;
      for (int i = 0; i < W; i++) tag_d[i] = rob_tail_q + TW'(i);
      src1_ready_d = acc_src1;
      src2_ready_d = acc_src2;
    end else if (valid_q && bus.issue_ready_in) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      src1_ready_d = hold_src1;
      src2_ready_d = hold_src2;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q      <= 1'b0;
      payload_q    <= '0;
      tag_q        <= '0;
      src1_ready_q <= '0;
      src2_ready_q <= '0;
      busy_q       <= '0;
      rob_tail_q   <= '0;
      credits_q    <= CRW'(ROB_DEPTH);
    end else begin
      valid_q      <= valid_d;
      payload_q    <= payload_d;
      tag_q        <= tag_d;
      src1_ready_q <= src1_ready_d;
      src2_ready_q <= src2_ready_d;
      busy_q       <= busy_d;
      rob_tail_q   <= rob_tail_d;
      credits_q    <= credits_d;
    end
  end

  // Committing more entries than were allocated is a caller bug.
  credit_overflow_a : assert property (@(posedge clk_in) disable iff (rst_in)
    credits_sum <= (CRW+1)'(ROB_DEPTH));

  assign bus.rename_ready_out     = rename_ready;
  assign bus.issue_valid_out      = valid_q;
  assign bus.issue_payload_out    = payload_q;
  assign bus.issue_rob_tag_out    = tag_q;
  assign bus.issue_src1_ready_out = src1_ready_q;
  assign bus.issue_src2_ready_out = src2_ready_q;
endmodule

// File: tb/tb_dispatch_stage.sv
// Self-checking bench for dispatch_stage: reference model plus a scoreboard of
// expected output groups, and directed scenario tasks.
module tb_dispatch_stage;
  import processor_help::*;

  localparam int W         = SUPER_SCALAR_WIDTH;
  localparam int P         = PHYSICAL_REGISTER_FILE_SIZE;
  localparam int PW        = PHYS_REG_WIDTH;
  localparam int ROB_DEPTH = 32;
  localparam int WBP       = 2;
  localparam int TW        = $clog2(ROB_DEPTH);

  typedef struct packed {
    RenameResult [W-1:0]  p;
    logic [W-1:0][TW-1:0] tag;
    logic [W-1:0]         s1;
    logic [W-1:0]         s2;
  } exp_group_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dispatch_stage_if #(.ROB_DEPTH(ROB_DEPTH), .WRITEBACK_PORTS(WBP)) bus ();

  dispatch_stage #(.ROB_DEPTH(ROB_DEPTH), .WRITEBACK_PORTS(WBP)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  exp_group_t sb[$];
  logic m_valid;
  logic [P-1:0] m_busy;
  logic [TW-1:0] m_tail;
  int m_credits;
  int n_acc, n_drain;

  function automatic RenameResult mk(int d, int s1, int s2);
    RenameResult r;
    r.opcode               = 8'($urandom);
    r.destination_register = PW'(d);
    r.source_register_1    = PW'(s1);
    r.source_register_2    = PW'(s2);
    return r;
  endfunction

  function automatic logic model_src_ready(int slot, logic [PW-1:0] s);
    logic r;
    if (s == '0) return 1'b1;
    for (int j = 0; j < slot; j++)
      if (bus.rename_payload_in[j].destination_register == s) return 1'b0;
    r = !m_busy[s];
    for (int k = 0; k < WBP; k++)
      if (bus.writeback_valid_in[k] && bus.writeback_tag_in[k] == s) r = 1'b1;
    return r;
  endfunction

  task automatic idle_inputs();
    bus.rename_valid_in    = 1'b0;
    bus.rename_payload_in  = '0;
    bus.issue_ready_in     = 1'b1;
    bus.writeback_valid_in = '0;
    bus.writeback_tag_in   = '0;
    bus.commit_count_in    = '0;
  endtask

  task automatic model_reset();
    m_valid   = 1'b0;
    m_busy    = '0;
    m_tail    = '0;
    m_credits = ROB_DEPTH;
    n_acc     = 0;
    n_drain   = 0;
    sb.delete();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: compare against the model with inputs applied, then advance.
  task automatic cycle();
    exp_group_t g, h;
    logic exp_rdy, acc;
    #1;
    exp_rdy = (!m_valid || bus.issue_ready_in) && (m_credits >= W);
    checks++;
    if (bus.rename_ready_out !== exp_rdy) begin
      errors++;
      $display("FAIL rename_ready: got %b expected %b", bus.rename_ready_out, exp_rdy);
    end
    checks++;
    if (bus.issue_valid_out !== m_valid) begin
      errors++;
      $display("FAIL issue_valid: got %b expected %b", bus.issue_valid_out, m_valid);
    end
    acc = bus.rename_valid_in && exp_rdy;
    if (m_valid && bus.issue_ready_in) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL drain: group drained but scoreboard empty");
      end else begin
        h     = sb.pop_front();
        g.p   = bus.issue_payload_out;
        g.tag = bus.issue_rob_tag_out;
        g.s1  = bus.issue_src1_ready_out;
        g.s2  = bus.issue_src2_ready_out;
        if (g !== h) begin
          errors++;
          $display("FAIL drain_group: got tags %0d/%0d s1 %b s2 %b payload %h expected tags %0d/%0d s1 %b s2 %b payload %h",
                   g.tag[0], g.tag[1], g.s1, g.s2, g.p, h.tag[0], h.tag[1], h.s1, h.s2, h.p);
        end else begin
          $display("drain  tags %0d/%0d src1 %b src2 %b", g.tag[0], g.tag[1], g.s1, g.s2);
        end
        n_drain++;
      end
    end else if (m_valid && sb.size() > 0) begin
      h = sb.pop_front();
      for (int i = 0; i < W; i++)
        for (int k = 0; k < WBP; k++)
          if (bus.writeback_valid_in[k]) begin
            if (bus.writeback_tag_in[k] == h.p[i].source_register_1) h.s1[i] = 1'b1;
            if (bus.writeback_tag_in[k] == h.p[i].source_register_2) h.s2[i] = 1'b1;
          end
      sb.push_front(h);
    end
    if (acc) begin
      for (int i = 0; i < W; i++) begin
        g.p[i]   = bus.rename_payload_in[i];
        g.tag[i] = m_tail + TW'(i);
        g.s1[i]  = model_src_ready(i, bus.rename_payload_in[i].source_register_1);
        g.s2[i]  = model_src_ready(i, bus.rename_payload_in[i].source_register_2);
      end
      sb.push_back(g);
      n_acc++;
      $display("accept tags %0d/%0d src1 %b src2 %b", g.tag[0], g.tag[1], g.s1, g.s2);
    end
    for (int k = 0; k < WBP; k++)
      if (bus.writeback_valid_in[k]) m_busy[bus.writeback_tag_in[k]] = 1'b0;
    if (acc)
      for (int i = 0; i < W; i++)
        if (bus.rename_payload_in[i].destination_register != '0)
          m_busy[bus.rename_payload_in[i].destination_register] = 1'b1;
    m_credits = m_credits - (acc ? W : 0) + int'(bus.commit_count_in);
    if (acc) m_tail = m_tail + TW'(W);
    m_valid = acc ? 1'b1 : ((m_valid && bus.issue_ready_in) ? 1'b0 : m_valid);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.issue_valid_out !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", bus.issue_valid_out);
    end
    checks++;
    if (bus.rename_ready_out !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", bus.rename_ready_out);
    end
    checks++;
    if (bus.issue_rob_tag_out !== '0 || bus.issue_payload_out !== '0 ||
        bus.issue_src1_ready_out !== '0 || bus.issue_src2_ready_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got tags %h payload %h s1 %b s2 %b expected all zero",
               bus.issue_rob_tag_out, bus.issue_payload_out,
               bus.issue_src1_ready_out, bus.issue_src2_ready_out);
    end
  endtask

  task automatic test_intra_group();
    bus.rename_valid_in      = 1'b1;
    bus.rename_payload_in[0] = mk(40, 1, 2);
    bus.rename_payload_in[1] = mk(41, 40, 3);
    cycle();
    bus.rename_valid_in = 1'b0;
    checks++;
    if (bus.issue_rob_tag_out[0] !== 5'd0 || bus.issue_rob_tag_out[1] !== 5'd1) begin
      errors++; $display("FAIL intra_tags: got %0d/%0d expected 0/1",
                         bus.issue_rob_tag_out[0], bus.issue_rob_tag_out[1]);
    end
    checks++;
    if (bus.issue_src1_ready_out !== 2'b01 || bus.issue_src2_ready_out !== 2'b11) begin
      errors++; $display("FAIL intra_ready: got s1 %b s2 %b expected s1 01 s2 11",
                         bus.issue_src1_ready_out, bus.issue_src2_ready_out);
    end
    cycle();
  endtask

  task automatic test_held_wakeup();
    RenameResult [W-1:0] grp;
    grp[0] = mk(42, 40, 0);
    grp[1] = mk(43, 41, 5);
    bus.issue_ready_in    = 1'b0;
    bus.rename_valid_in   = 1'b1;
    bus.rename_payload_in = grp;
    cycle();
    bus.rename_valid_in = 1'b0;
    checks++;
    if (bus.issue_src1_ready_out !== 2'b00 || bus.issue_src2_ready_out !== 2'b11) begin
      errors++; $display("FAIL held_initial: got s1 %b s2 %b expected s1 00 s2 11",
                         bus.issue_src1_ready_out, bus.issue_src2_ready_out);
    end
    bus.writeback_valid_in[0] = 1'b1;
    bus.writeback_tag_in[0]   = PW'(40);
    cycle();
    bus.writeback_valid_in = '0;
    checks++;
    if (bus.issue_src1_ready_out !== 2'b01) begin
      errors++; $display("FAIL held_wakeup: got s1 %b expected 01", bus.issue_src1_ready_out);
    end
    checks++;
    if (bus.issue_payload_out !== grp || bus.issue_rob_tag_out[0] !== 5'd2 ||
        bus.issue_rob_tag_out[1] !== 5'd3) begin
      errors++; $display("FAIL held_stable: got payload %h tags %0d/%0d expected payload %h tags 2/3",
                         bus.issue_payload_out, bus.issue_rob_tag_out[0],
                         bus.issue_rob_tag_out[1], grp);
    end
    cycle();
    checks++;
    if (bus.issue_src1_ready_out !== 2'b01) begin
      errors++; $display("FAIL held_sticky: got s1 %b expected 01", bus.issue_src1_ready_out);
    end
    // Drain and accept together, with p41 bypassed at accept time.
    bus.issue_ready_in        = 1'b1;
    bus.rename_valid_in       = 1'b1;
    bus.rename_payload_in[0]  = mk(44, 41, 42);
    bus.rename_payload_in[1]  = mk(0, 43, 0);
    bus.writeback_valid_in[0] = 1'b1;
    bus.writeback_tag_in[0]   = PW'(41);
    cycle();
    bus.rename_valid_in    = 1'b0;
    bus.writeback_valid_in = '0;
    checks++;
    if (bus.issue_rob_tag_out[0] !== 5'd4 || bus.issue_src1_ready_out !== 2'b01 ||
        bus.issue_src2_ready_out !== 2'b10) begin
      errors++; $display("FAIL bypass: got tag0 %0d s1 %b s2 %b expected tag0 4 s1 01 s2 10",
                         bus.issue_rob_tag_out[0], bus.issue_src1_ready_out,
                         bus.issue_src2_ready_out);
    end
    cycle();
  endtask

  task automatic test_set_wins();
    bus.rename_valid_in       = 1'b1;
    bus.rename_payload_in[0]  = mk(50, 0, 0);
    bus.rename_payload_in[1]  = mk(0, 0, 0);
    bus.writeback_valid_in[1] = 1'b1;
    bus.writeback_tag_in[1]   = PW'(50);
    cycle();
    bus.writeback_valid_in   = '0;
    bus.rename_payload_in[0] = mk(0, 50, 0);
    bus.rename_payload_in[1] = mk(0, 0, 50);
    cycle();
    bus.rename_valid_in = 1'b0;
    checks++;
    if (bus.issue_src1_ready_out !== 2'b10 || bus.issue_src2_ready_out !== 2'b01) begin
      errors++; $display("FAIL set_wins: got s1 %b s2 %b expected s1 10 s2 01",
                         bus.issue_src1_ready_out, bus.issue_src2_ready_out);
    end
    cycle();
  endtask

  task automatic test_credit_exhaust();
    do_reset();
    bus.rename_valid_in = 1'b1;
    for (int n = 0; n < 16; n++) begin
      bus.rename_payload_in[0] = mk($urandom_range(0, P-1), $urandom_range(0, P-1), $urandom_range(0, P-1));
      bus.rename_payload_in[1] = mk($urandom_range(0, P-1), $urandom_range(0, P-1), $urandom_range(0, P-1));
      cycle();
    end
    checks++;
    if (bus.rename_ready_out !== 1'b0) begin
      errors++; $display("FAIL credits_empty: got ready %b expected 0", bus.rename_ready_out);
    end
    cycle();
    checks++;
    if (bus.issue_valid_out !== 1'b0) begin
      errors++; $display("FAIL credits_drain: got valid %b expected 0", bus.issue_valid_out);
    end
    bus.rename_valid_in = 1'b0;
    bus.commit_count_in = 2'd2;
    cycle();
    bus.commit_count_in = '0;
    checks++;
    if (bus.rename_ready_out !== 1'b1) begin
      errors++; $display("FAIL credits_return: got ready %b expected 1", bus.rename_ready_out);
    end
    bus.rename_valid_in      = 1'b1;
    bus.rename_payload_in[0] = mk(7, 8, 9);
    bus.rename_payload_in[1] = mk(10, 7, 11);
    cycle();
    bus.rename_valid_in = 1'b0;
    checks++;
    if (bus.issue_rob_tag_out[0] !== 5'd0 || bus.issue_rob_tag_out[1] !== 5'd1) begin
      errors++; $display("FAIL tag_wrap: got %0d/%0d expected 0/1",
                         bus.issue_rob_tag_out[0], bus.issue_rob_tag_out[1]);
    end
    cycle();
  endtask

  task automatic test_back_to_back();
    logic pattern [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [TW-1:0] exp_tag;
    do_reset();
    exp_tag = '0;
    bus.rename_valid_in = 1'b1;
    for (int n = 0; n < 6; n++) begin
      bus.issue_ready_in       = pattern[n];
      bus.rename_payload_in[0] = mk($urandom_range(1, P-1), $urandom_range(0, P-1), $urandom_range(0, P-1));
      bus.rename_payload_in[1] = mk($urandom_range(0, P-1), $urandom_range(0, P-1), $urandom_range(0, P-1));
      #1;
      if (!pattern[n]) begin
        checks++;
        if (bus.rename_ready_out !== 1'b0) begin
          errors++; $display("FAIL stall_ready: cycle %0d got %b expected 0", n, bus.rename_ready_out);
        end
      end
      if (m_valid && pattern[n]) begin
        checks++;
        if (bus.issue_rob_tag_out[0] !== exp_tag || bus.issue_rob_tag_out[1] !== exp_tag + 5'd1) begin
          errors++; $display("FAIL tag_sequence: got %0d/%0d expected %0d/%0d",
                             bus.issue_rob_tag_out[0], bus.issue_rob_tag_out[1], exp_tag, exp_tag + 5'd1);
        end
        exp_tag = exp_tag + 5'd2;
      end
      cycle();
    end
    bus.rename_valid_in = 1'b0;
    bus.issue_ready_in  = 1'b1;
    for (int n = 0; n < 4 && m_valid; n++) cycle();
    checks++;
    if (bus.issue_valid_out !== 1'b0 || n_drain != n_acc || n_acc != 4 || sb.size() != 0) begin
      errors++; $display("FAIL flow_count: got valid %b accepted %0d drained %0d pending %0d expected 0/4/4/0",
                         bus.issue_valid_out, n_acc, n_drain, sb.size());
    end
  endtask

  task automatic test_async_reset();
    bus.issue_ready_in       = 1'b0;
    bus.rename_valid_in      = 1'b1;
    bus.rename_payload_in[0] = mk(40, 1, 2);
    bus.rename_payload_in[1] = mk(0, 0, 0);
    cycle();
    bus.rename_valid_in = 1'b0;
    cycle();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.issue_valid_out !== 1'b0) begin
      errors++; $display("FAIL async_reset_valid: got %b expected 0", bus.issue_valid_out);
    end
    checks++;
    if (bus.rename_ready_out !== 1'b1) begin
      errors++; $display("FAIL async_reset_ready: got %b expected 1", bus.rename_ready_out);
    end
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.rename_valid_in      = 1'b1;
    bus.rename_payload_in[0] = mk(0, 40, 40);
    bus.rename_payload_in[1] = mk(0, 40, 0);
    cycle();
    bus.rename_valid_in = 1'b0;
    checks++;
    if (bus.issue_src1_ready_out !== 2'b11 || bus.issue_src2_ready_out !== 2'b11 ||
        bus.issue_rob_tag_out[0] !== 5'd0) begin
      errors++; $display("FAIL after_reset: got s1 %b s2 %b tag0 %0d expected s1 11 s2 11 tag0 0",
                         bus.issue_src1_ready_out, bus.issue_src2_ready_out, bus.issue_rob_tag_out[0]);
    end
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_intra_group();
    test_held_wakeup();
    test_set_wins();
    test_credit_exhaust();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
